finn_rtl_krnl_final_example_rd_scheduler: RTL and testbench
===========================================================

Name: finn_rtl_krnl_final_example_rd_scheduler

Overview:
- Read-transaction scheduler for the kernel's AXI4 master read channel.
- Takes one start command carrying a base address and a transfer length in beats.
- Splits the transfer into AR bursts of at most C_BURST_LEN beats and caps in-flight bursts at C_MAX_OUTSTANDING, counting issued bursts against returned RLAST handshakes.
- Pulses done once every burst has completed. Sits between the kernel control registers and the m_axi read port.

Parameters:
- C_ADDR_WIDTH, 64, AXI address width.
- C_XFER_SIZE_WIDTH, 32, width of the transfer length in beats.
- C_BURST_LEN, 16, max beats per burst; power of 2, 1..256.
- C_MAX_OUTSTANDING, 16, max bursts in flight; >=1.
- C_BYTES_PER_BEAT, 64, bytes per data beat; power of 2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- ctrl_start  in  1  start pulse; honoured only in IDLE.
- ctrl_addr_offset  in  C_ADDR_WIDTH  byte base address; sampled on accepted start.
- ctrl_xfer_beats  in  C_XFER_SIZE_WIDTH  total beats; sampled on accepted start.
- ctrl_busy  out  1  high in ISSUE/DRAIN/DONE.
- ctrl_done  out  1  one-cycle completion pulse.
- ctrl_err  out  1  sticky protocol error; cleared on accepted start.
- arvalid  out  1  AXI AR valid.
- arready  in  1  AXI AR ready.
- araddr  out  C_ADDR_WIDTH  burst start address.
- arlen  out  8  beats-1 of the current burst.
- rlast_hs  in  1  one-cycle strobe for rvalid&rready&rlast.

Behaviour:
- Reset (async, any time, including mid-transfer):
  - state=IDLE; outstanding=0; remaining=0.
  - arvalid=0, araddr=0, arlen=0, ctrl_busy=0, ctrl_done=0, ctrl_err=0.
  - No done pulse follows a reset.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - ctrl_start=1 with xfer_beats!=0: latch addr and remaining, clear err, go to ISSUE.
  - ctrl_start=1 with xfer_beats==0: clear err, go to DONE; no AR is issued.
- ISSUE:
  - arvalid = (outstanding < C_MAX_OUTSTANDING); araddr/arlen driven from registers.
  - First arvalid appears the cycle after start is accepted.
  - arlen = min(remaining, C_BURST_LEN) - 1.
- On arvalid & arready:
  - araddr += (arlen+1)*C_BYTES_PER_BEAT.
  - remaining -= arlen+1.
  - outstanding += 1.
  - If the new remaining is 0, go to DRAIN; otherwise stay in ISSUE.
- AXI stability: while arvalid=1 and arready=0, arvalid, araddr and arlen hold. This is guaranteed because outstanding only decreases while waiting.
- Address arithmetic:
  - Modulo 2^C_ADDR_WIDTH; wrap is silent.
  - No 4 KB boundary splitting; the caller aligns the base to C_BURST_LEN*C_BYTES_PER_BEAT.
- Outstanding counter, width clog2(C_MAX_OUTSTANDING+1):
  - AR accept and rlast_hs in the same cycle: outstanding unchanged.
  - rlast_hs while outstanding==0: counter saturates at 0 and ctrl_err=1 (sticky).
- DRAIN: arvalid=0; go to DONE on the edge after outstanding==0 is observed.
- DONE: ctrl_done=1 for exactly one cycle, then go to IDLE. ctrl_busy is high during DONE and low in IDLE.
- ctrl_start outside IDLE is ignored; no latch, no error.
- Outputs ctrl_done, ctrl_busy and ctrl_err are driven from state/registers; none is combinational from inputs.

Test Plan:
- Defaults, arready=1, rlast_hs returned 4 cycles after each AR, start addr=0x1000 beats=40:
  - AR sequence is (0x1000, arlen 15), (0x1400, 15), (0x1800, 7).
  - ctrl_done pulses once, 2 cycles after the third rlast_hs.
  - ctrl_busy falls the cycle after done.
- C_MAX_OUTSTANDING=2, no rlast_hs, beats=64:
  - Exactly 2 ARs are accepted, then arvalid=0.
  - One rlast_hs leads to a third AR the next cycle.
  - Holding arready=0 keeps araddr/arlen stable.
- beats=0:
  - No arvalid ever.
  - ctrl_busy=1 for 1 cycle with ctrl_done=1 in that cycle; ctrl_err=0.
- AR accept coincident with rlast_hs at outstanding=1: outstanding stays 1.
- rlast_hs while idle (outstanding=0): ctrl_err=1 and stays set; the next accepted start clears it.
- rst asserted mid-ISSUE after 1 of 3 bursts:
  - All outputs are 0 immediately (async), with no done pulse.
  - A new start of 16 beats at 0x0 issues a single AR (0x0, arlen 15).

Source files
------------

// File: rtl/finn_rtl_krnl_final_example_rd_scheduler.sv
// AXI4 read-address scheduler: splits one start command into bursts of at most
// C_BURST_LEN beats, limits bursts in flight, and pulses done when all have returned.
module finn_rtl_krnl_final_example_rd_scheduler #(
  parameter int C_ADDR_WIDTH      = 64,
  parameter int C_XFER_SIZE_WIDTH = 32,
  parameter int C_BURST_LEN       = 16,
  parameter int C_MAX_OUTSTANDING = 16,
  parameter int C_BYTES_PER_BEAT  = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ctrl_start,
  input  logic [C_ADDR_WIDTH-1:0]      ctrl_addr_offset,
  input  logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_beats,
  output logic                         ctrl_busy,
  output logic                         ctrl_done,
  output logic                         ctrl_err,
  output logic                         arvalid,
  input  logic                         arready,
  output logic [C_ADDR_WIDTH-1:0]      araddr,
  output logic [7:0]                   arlen,
  input  logic                         rlast_hs
);

  // state | meaning
  // IDLE  | waiting for ctrl_start
  // ISSUE | presenting AR bursts while the in-flight limit allows
  // DRAIN | all bursts issued, waiting for the last RLAST
  // DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam int OUT_W = $clog2(C_MAX_OUTSTANDING + 1);
  localparam int BEAT_SHIFT = $clog2(C_BYTES_PER_BEAT);
  localparam logic [C_XFER_SIZE_WIDTH-1:0] MAX_BEATS = C_XFER_SIZE_WIDTH'(C_BURST_LEN);
  localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(C_MAX_OUTSTANDING);

  state_t state, state_nxt;

  logic [C_ADDR_WIDTH-1:0]      addr_q;
  logic [C_XFER_SIZE_WIDTH-1:0] remaining_q;
  logic [C_XFER_SIZE_WIDTH-1:0] remaining_nxt;
  logic [C_XFER_SIZE_WIDTH-1:0] burst_beats;
  logic [C_ADDR_WIDTH-1:0]      addr_incr;
  logic [OUT_W-1:0]             outstanding_q;
  logic                         err_q;
  logic                         start_ok;
  logic                         ar_hs;

  assign start_ok      = (state == IDLE) && ctrl_start;
  assign burst_beats   = (remaining_q >= MAX_BEATS) ? MAX_BEATS : remaining_q;
  assign remaining_nxt = remaining_q - burst_beats;
  assign addr_incr     = C_ADDR_WIDTH'(burst_beats) << BEAT_SHIFT;

  // outstanding only falls while AR waits, so arvalid can never drop mid-handshake
  assign arvalid = (state == ISSUE) && (outstanding_q < MAX_OUT);
  assign ar_hs   = arvalid && arready;
  assign araddr  = addr_q;
  assign arlen   = (remaining_q == '0) ? 8'd0 : 8'(burst_beats - 1'b1);

  assign ctrl_busy = (state != IDLE);
  assign ctrl_done = (state == DONE);
  assign ctrl_err  = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ctrl_start) begin
          state_nxt = (ctrl_xfer_beats != '0) ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        if (ar_hs && (remaining_nxt == '0)) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (outstanding_q == '0) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      remaining_q <= '0;
    end else if (start_ok) begin
      addr_q      <= ctrl_addr_offset;
      remaining_q <= ctrl_xfer_beats;
    end else if (ar_hs) begin
      addr_q      <= addr_q + addr_incr;
      remaining_q <= remaining_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding_q <= '0;
    end else begin
      case ({ar_hs, rlast_hs})
        2'b10: outstanding_q <= outstanding_q + 1'b1;
        2'b01: begin
          if (outstanding_q != '0) begin
            outstanding_q <= outstanding_q - 1'b1;
          end
        end
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  // a stray RLAST wins over the clear so a coincident start cannot hide it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (rlast_hs && !ar_hs && (outstanding_q == '0)) begin
      err_q <= 1'b1;
    end else if (start_ok) begin
      err_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_finn_rtl_krnl_final_example_rd_scheduler.sv
// Scoreboard bench for the read scheduler: default instance plus a 2-outstanding instance.
module tb_finn_rtl_krnl_final_example_rd_scheduler;

  typedef struct {
    logic [63:0] a;
    logic [7:0]  l;
  } ar_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start_a = 0, arready_a = 0, rlast_man_a = 0, auto_a = 0;
  logic [63:0] addr_a = '0;
  logic [31:0] beats_a = '0;
  logic        busy_a, done_a, err_a, arvalid_a;
  logic [63:0] araddr_a;
  logic [7:0]  arlen_a;
  logic        rlast_hs_a;
  logic [3:0]  pipe_a = '0;
  logic        acc_a = 0;

  logic        start_b = 0, arready_b = 0, rlast_b = 0;
  logic [63:0] addr_b = '0;
  logic [31:0] beats_b = '0;
  logic        busy_b, done_b, err_b, arvalid_b;
  logic [63:0] araddr_b;
  logic [7:0]  arlen_b;

  assign rlast_hs_a = rlast_man_a | (auto_a & pipe_a[3]);

  finn_rtl_krnl_final_example_rd_scheduler dut_a (
    .clk(clk), .rst(rst), .ctrl_start(start_a), .ctrl_addr_offset(addr_a),
    .ctrl_xfer_beats(beats_a), .ctrl_busy(busy_a), .ctrl_done(done_a), .ctrl_err(err_a),
    .arvalid(arvalid_a), .arready(arready_a), .araddr(araddr_a), .arlen(arlen_a),
    .rlast_hs(rlast_hs_a));

  finn_rtl_krnl_final_example_rd_scheduler #(.C_MAX_OUTSTANDING(2)) dut_b (
    .clk(clk), .rst(rst), .ctrl_start(start_b), .ctrl_addr_offset(addr_b),
    .ctrl_xfer_beats(beats_b), .ctrl_busy(busy_b), .ctrl_done(done_b), .ctrl_err(err_b),
    .arvalid(arvalid_b), .arready(arready_b), .araddr(araddr_b), .arlen(arlen_b),
    .rlast_hs(rlast_b));

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  ar_t q_a[$];
  ar_t q_b[$];
  int ar_cnt_a = 0, ar_cnt_b = 0;
  int done_cnt_a = 0, done_cyc_a = 0, last_rl_a = 0;
  logic busy_at_done_a = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    pipe_a = {pipe_a[2:0], acc_a};
  end

  // monitor: pops expected ARs whenever a handshake is visible
  always @(negedge clk) begin
    acc_a = 1'b0;
    if (!rst) begin
      if (arvalid_a && arready_a) begin
        acc_a = 1'b1;
        ar_cnt_a++;
        if (q_a.size() == 0) begin
          chk("ar_a unexpected", 1, 0);
        end else begin
          ar_t e;
          e = q_a.pop_front();
          chk("ar_a addr", araddr_a, e.a);
          chk("ar_a len", {56'd0, arlen_a}, {56'd0, e.l});
        end
      end
      if (rlast_hs_a) last_rl_a = cyc;
      if (done_a) begin
        done_cnt_a++;
        done_cyc_a = cyc;
        busy_at_done_a = busy_a;
      end
      if (arvalid_b && arready_b) begin
        ar_cnt_b++;
        if (q_b.size() == 0) begin
          chk("ar_b unexpected", 1, 0);
        end else begin
          ar_t e;
          e = q_b.pop_front();
          chk("ar_b addr", araddr_b, e.a);
          chk("ar_b len", {56'd0, arlen_b}, {56'd0, e.l});
        end
      end
    end
  end

  task automatic push_a(input logic [63:0] a, input logic [7:0] l);
    ar_t e;
    e.a = a;
    e.l = l;
    q_a.push_back(e);
  endtask

  task automatic push_b(input logic [63:0] a, input logic [7:0] l);
    ar_t e;
    e.a = a;
    e.l = l;
    q_b.push_back(e);
  endtask

  task automatic start_cmd_a(input logic [63:0] a, input logic [31:0] b);
    start_a = 1;
    addr_a  = a;
    beats_a = b;
    tick();
    start_a = 0;
  endtask

  task automatic wait_done_a(input string nm, input int lim);
    int d0;
    int k;
    d0 = done_cnt_a;
    k = 0;
    while (done_cnt_a == d0 && k < lim) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk(nm, done_cnt_a - d0, 1);
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, " arvalid"}, arvalid_a, 0);
    chk({nm, " araddr"}, araddr_a, 0);
    chk({nm, " arlen"}, arlen_a, 0);
    chk({nm, " busy"}, busy_a, 0);
    chk({nm, " done"}, done_a, 0);
    chk({nm, " err"}, err_a, 0);
  endtask

  initial begin
    int d0;
    int n0;
    repeat (2) @(posedge clk);
    #3;
    chk_idle_outputs("reset");
    chk("reset b arvalid", arvalid_b, 0);
    @(posedge clk);
    #1;
    rst = 0;
    tick();

    // three bursts, auto RLAST 4 cycles after each AR
    auto_a = 1;
    arready_a = 1;
    push_a(64'h1000, 8'd15);
    push_a(64'h1400, 8'd15);
    push_a(64'h1800, 8'd7);
    start_cmd_a(64'h1000, 32'd40);
    wait_done_a("t1 done", 60);
    chk("t1 done after rlast", done_cyc_a - last_rl_a, 2);
    chk("t1 busy at done", busy_at_done_a, 1);
    @(negedge clk);
    chk("t1 busy after done", busy_a, 0);
    chk("t1 done one cycle", done_a, 0);
    chk("t1 ar count", ar_cnt_a, 3);
    chk("t1 queue empty", q_a.size(), 0);

    // zero-length transfer
    tick();
    n0 = ar_cnt_a;
    start_cmd_a(64'h9000, 32'd0);
    @(negedge clk);
    chk("t2 busy", busy_a, 1);
    chk("t2 done", done_a, 1);
    chk("t2 err", err_a, 0);
    @(negedge clk);
    chk("t2 busy low", busy_a, 0);
    chk("t2 done low", done_a, 0);
    chk("t2 no ar", ar_cnt_a - n0, 0);

    // stray RLAST while idle sets sticky error, next start clears it
    tick();
    auto_a = 0;
    rlast_man_a = 1;
    tick();
    rlast_man_a = 0;
    @(negedge clk);
    chk("t3 err set", err_a, 1);
    repeat (3) tick();
    chk("t3 err sticky", err_a, 1);
    auto_a = 1;
    push_a(64'h2000, 8'd15);
    start_cmd_a(64'h2000, 32'd16);
    chk("t3 err cleared", err_a, 0);
    wait_done_a("t3 done", 40);

    // AR accept coincident with RLAST at outstanding 1
    tick();
    auto_a = 0;
    arready_a = 0;
    push_a(64'h3000, 8'd15);
    push_a(64'h3400, 8'd15);
    start_cmd_a(64'h3000, 32'd32);
    arready_a = 1;
    tick();
    rlast_man_a = 1;
    tick();
    arready_a = 0;
    rlast_man_a = 0;
    d0 = done_cnt_a;
    repeat (4) tick();
    chk("t4 no early done", done_cnt_a - d0, 0);
    chk("t4 still busy", busy_a, 1);
    chk("t4 no err", err_a, 0);
    rlast_man_a = 1;
    tick();
    rlast_man_a = 0;
    wait_done_a("t4 done", 10);
    chk("t4 queue empty", q_a.size(), 0);

    // async reset mid-ISSUE after one of three bursts
    tick();
    push_a(64'h5000, 8'd15);
    start_cmd_a(64'h5000, 32'd48);
    arready_a = 1;
    tick();
    arready_a = 0;
    chk("t5 arvalid before rst", arvalid_a, 1);
    d0 = done_cnt_a;
    #3;
    rst = 1;
    #1;
    chk_idle_outputs("t5 async rst");
    q_a.delete();
    @(posedge clk);
    #1;
    rst = 0;
    repeat (3) tick();
    chk("t5 no done after rst", done_cnt_a - d0, 0);
    n0 = ar_cnt_a;
    auto_a = 1;
    arready_a = 1;
    push_a(64'h0, 8'd15);
    start_cmd_a(64'h0, 32'd16);
    wait_done_a("t5 done", 40);
    chk("t5 single ar", ar_cnt_a - n0, 1);
    chk("t5 queue empty", q_a.size(), 0);

    // outstanding limit of 2 on the second instance
    arready_b = 1;
    push_b(64'h0, 8'd15);
    push_b(64'h400, 8'd15);
    start_b = 1;
    addr_b = 64'h0;
    beats_b = 32'd64;
    tick();
    start_b = 0;
    repeat (6) tick();
    @(negedge clk);
    chk("t6 two ars", ar_cnt_b, 2);
    chk("t6 arvalid capped", arvalid_b, 0);
    tick();
    arready_b = 0;
    rlast_b = 1;
    tick();
    rlast_b = 0;
    @(negedge clk);
    chk("t6 arvalid after rlast", arvalid_b, 1);
    chk("t6 araddr", araddr_b, 64'h800);
    chk("t6 arlen", {56'd0, arlen_b}, 64'd15);
    repeat (3) @(negedge clk);
    chk("t6 arvalid held", arvalid_b, 1);
    chk("t6 araddr held", araddr_b, 64'h800);
    chk("t6 arlen held", {56'd0, arlen_b}, 64'd15);
    push_b(64'h800, 8'd15);
    @(posedge clk);
    #1;
    arready_b = 1;
    tick();
    arready_b = 0;
    @(negedge clk);
    chk("t6 third ar", ar_cnt_b, 3);
    chk("t6 capped again", arvalid_b, 0);
    chk("t6 queue empty", q_b.size(), 0);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
